// File: rtl/adam_timer_seqr.sv
// +--------------------------------------------------------------------------+
// | adam_timer_seqr: APB master that programs a timer, services its irqs     |
// | and shuts it down after N events or on stop.            Revision: 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

module adam_timer_seqr #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE       = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [DATA_WIDTH-1:0]   cfg_pr,
  input  logic [DATA_WIDTH-1:0]   cfg_vr,
  input  logic [DATA_WIDTH-1:0]   cfg_arr,
  input  logic [15:0]             cfg_events,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [15:0]             event_cnt,
  input  logic                    irq,
  input  logic                    pause_req,
  output logic                    pause_ack,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int                    c_strb_w  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] c_off_cr  = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] c_off_pr  = ADDR_WIDTH'(32'h04);
  localparam logic [ADDR_WIDTH-1:0] c_off_vr  = ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] c_off_arr = ADDR_WIDTH'(32'h0C);
  localparam logic [ADDR_WIDTH-1:0] c_off_er  = ADDR_WIDTH'(32'h10);
  localparam logic [ADDR_WIDTH-1:0] c_off_ier = ADDR_WIDTH'(32'h14);

  typedef enum logic [3:0] {
    IDLE, W_CR0, W_PR, W_IER, W_VR, W_ARR, W_CR1, WAIT_IRQ, W_ER, W_CRX, PAUSED
  } state_t;

  typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_t;

  state_t                r_state, w_state_d;
  state_t                r_ret, w_ret_d;
  phase_t                r_phase, w_phase_d;
  logic [DATA_WIDTH-1:0] r_pr, r_vr, r_arr;
  logic [15:0]           r_events;
  logic [15:0]           r_cnt, w_cnt_d, w_cnt_inc;
  logic                  r_busy, w_busy_d;
  logic                  r_done, w_done_d;
  logic                  r_err, w_err_d;
  logic                  w_load;
  logic                  w_is_wr;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_unused;

  assign w_unused  = ^prdata;
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

  // Register address and data are a pure function of the write state, so
  // both stay stable for the whole SETUP/ACCESS pair.
  always_comb begin
    w_is_wr = 1'b1;
    w_off   = '0;
    w_wdata = '0;
    unique case (r_state)
      W_CR0:   begin w_off = c_off_cr;  w_wdata = '0;                 end
      W_PR:    begin w_off = c_off_pr;  w_wdata = r_pr;               end
      W_IER:   begin w_off = c_off_ier; w_wdata = '1;                 end
      W_VR:    begin w_off = c_off_vr;  w_wdata = r_vr;               end
      W_ARR:   begin w_off = c_off_arr; w_wdata = r_arr;              end
      W_CR1:   begin w_off = c_off_cr;  w_wdata = DATA_WIDTH'(1);     end
      W_ER:    begin w_off = c_off_er;  w_wdata = DATA_WIDTH'(1);     end
      W_CRX:   begin w_off = c_off_cr;  w_wdata = '0;                 end
      default: w_is_wr = 1'b0;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_ret_d   = r_ret;
    w_phase_d = r_phase;
    w_cnt_d   = r_cnt;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;
    w_err_d   = 1'b0;
    w_load    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load    = 1'b1;
          w_cnt_d   = '0;
          w_busy_d  = 1'b1;
          w_state_d = W_CR0;
          w_phase_d = PH_GAP;
        end else if (pause_req) begin
          w_ret_d   = IDLE;
          w_state_d = PAUSED;
        end
      end
      WAIT_IRQ: begin
        if (stop) begin
          w_state_d = W_CRX;
          w_phase_d = PH_GAP;
        end else if (pause_req) begin
          w_ret_d   = WAIT_IRQ;
          w_state_d = PAUSED;
        end else if (irq) begin
          w_state_d = W_ER;
          w_phase_d = PH_GAP;
        end
      end
      PAUSED: begin
        if (!pause_req) w_state_d = r_ret;
      end
      default: begin
        unique case (r_phase)
          PH_GAP:   w_phase_d = PH_SETUP;
          PH_SETUP: w_phase_d = PH_ACCESS;
          default: begin
            if (pready) begin
              w_phase_d = PH_GAP;
              if (pslverr) begin
                w_state_d = IDLE;
                w_err_d   = 1'b1;
                w_busy_d  = 1'b0;
              end else begin
                unique case (r_state)
                  W_CR0: w_state_d = W_PR;
                  W_PR:  w_state_d = W_IER;
                  W_IER: w_state_d = W_VR;
                  W_VR:  w_state_d = W_ARR;
                  W_ARR: w_state_d = W_CR1;
                  W_CR1: w_state_d = WAIT_IRQ;
                  W_ER: begin
                    w_cnt_d   = w_cnt_inc;
                    w_state_d = (r_events != 16'd0 && w_cnt_inc == r_events) ? W_CRX : WAIT_IRQ;
                  end
                  default: begin
                    w_state_d = IDLE;
                    w_done_d  = 1'b1;
                    w_busy_d  = 1'b0;
                  end
                endcase
              end
            end
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ret    <= IDLE;
      r_phase  <= PH_GAP;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_pr     <= '0;
      r_vr     <= '0;
      r_arr    <= '0;
      r_events <= '0;
    end else begin
      r_state <= w_state_d;
      r_ret   <= w_ret_d;
      r_phase <= w_phase_d;
      r_cnt   <= w_cnt_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
      if (w_load) begin
        r_pr     <= cfg_pr;
        r_vr     <= cfg_vr;
        r_arr    <= cfg_arr;
        r_events <= cfg_events;
      end
    end
  end

  assign psel      = w_is_wr && (r_phase != PH_GAP);
  assign penable   = w_is_wr && (r_phase == PH_ACCESS);
  assign pwrite    = psel;
  assign paddr     = psel ? BASE + w_off : '0;
  assign pwdata    = psel ? w_wdata : '0;
  assign pstrb     = {c_strb_w{psel}};
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign event_cnt = r_cnt;
  assign pause_ack = (r_state == PAUSED);

endmodule

`default_nettype wire

// File: tb/tb_adam_timer_seqr.sv
// +--------------------------------------------------------------------------+
// | tb_adam_timer_seqr: scoreboard bench for the timer sequencer.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_adam_timer_seqr;

  localparam int             AW   = 32;
  localparam int             DW   = 32;
  localparam int             SW   = DW / 8;
  localparam logic [AW-1:0]  BASE = 32'h4000_1000;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, irq = 1'b0, pause_req = 1'b0;
  logic          pready = 1'b0, pslverr = 1'b0;
  logic [DW-1:0] cfg_pr = '0, cfg_vr = '0, cfg_arr = '0, prdata = '0;
  logic [15:0]   cfg_events = '0;
  logic          busy, done, err, pause_ack, psel, penable, pwrite;
  logic [15:0]   event_cnt;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;

  always #5 clk = ~clk;

  adam_timer_seqr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_pr(cfg_pr), .cfg_vr(cfg_vr), .cfg_arr(cfg_arr), .cfg_events(cfg_events),
    .busy(busy), .done(done), .err(err), .event_cnt(event_cnt),
    .irq(irq), .pause_req(pause_req), .pause_ack(pause_ack),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int total = 0, bad = 0;
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  int            exp_end[$];     // 0 = done, 1 = err
  logic [15:0]   exp_cnt[$];
  int            ws = 0;
  bit            err_en = 1'b0;
  logic [AW-1:0] err_addr = '0;
  int            wr_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected bus traffic for one run, derived from the register programming order.
  task automatic push_seq(input logic [DW-1:0] pr, vr, arr, input int n_er,
                          input int err_at, input logic [15:0] cnt);
    logic [AW-1:0] a[$];
    logic [DW-1:0] d[$];
    a.push_back(BASE + 32'h00); d.push_back(32'd0);
    a.push_back(BASE + 32'h04); d.push_back(pr);
    a.push_back(BASE + 32'h14); d.push_back(32'hFFFF_FFFF);
    a.push_back(BASE + 32'h08); d.push_back(vr);
    a.push_back(BASE + 32'h0C); d.push_back(arr);
    a.push_back(BASE + 32'h00); d.push_back(32'd1);
    for (int i = 0; i < n_er; i++) begin a.push_back(BASE + 32'h10); d.push_back(32'd1); end
    a.push_back(BASE + 32'h00); d.push_back(32'd0);
    for (int i = 0; i < a.size(); i++) begin
      if (err_at < 0 || i <= err_at) begin
        exp_addr.push_back(a[i]);
        exp_data.push_back(d[i]);
      end
    end
    exp_end.push_back(err_at >= 0 ? 1 : 0);
    exp_cnt.push_back(cnt);
  endtask

  // Slave + timer model and scoreboard monitor, sampled on the falling edge.
  int            acc = 0, acc_len = 0;
  logic          prev_psel = 1'b0, stable = 1'b1;
  logic [AW-1:0] su_addr = '0;
  logic [DW-1:0] su_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc = 0; pready = 1'b0; pslverr = 1'b0; prev_psel = 1'b0;
    end else begin
      if (psel && penable) begin
        pready  = (acc >= ws);
        pslverr = pready && err_en && (paddr == err_addr);
        acc++;
      end else begin
        acc = 0; pready = 1'b0; pslverr = 1'b0;
      end
      if (psel && !penable) begin
        check("setup_after_gap", prev_psel, 1'b0);
        su_addr = paddr; su_data = pwdata; acc_len = 0; stable = 1'b1;
      end
      if (psel && penable) begin
        acc_len++;
        if (paddr !== su_addr || pwdata !== su_data) stable = 1'b0;
        if (pready) begin
          wr_done++;
          if (exp_addr.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none", paddr, pwdata);
          end else begin
            check("wr_addr", paddr, exp_addr.pop_front());
            check("wr_data", pwdata, exp_data.pop_front());
          end
          check("stable", stable, 1'b1);
          check("access_len", acc_len, ws + 1);
          check("pwrite_pstrb", {pwrite, pstrb}, {1'b1, {SW{1'b1}}});
          if (paddr == BASE + 32'h10 && !pslverr) irq = 1'b0;
        end
      end
      prev_psel = psel;
      if (done || err) begin
        if (exp_end.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_end: got done=%0b err=%0b expected none", done, err);
        end else begin
          check("end_kind", {done, err}, exp_end.pop_front() == 1 ? 2'b01 : 2'b10);
          check("event_cnt", event_cnt, exp_cnt.pop_front());
          check("busy_at_end", busy, 1'b0);
        end
      end
    end
  end

  task automatic start_seq(input logic [DW-1:0] pr, vr, arr, input logic [15:0] ev);
    @(negedge clk);
    cfg_pr = pr; cfg_vr = vr; cfg_arr = arr; cfg_events = ev; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_pr = $urandom; cfg_vr = $urandom; cfg_arr = $urandom; cfg_events = 16'($urandom);
  endtask

  task automatic wait_writes(input int n);
    int t = 0;
    while (wr_done < n && t < 3000) begin @(negedge clk); t++; end
    check("wait_writes", wr_done >= n, 1'b1);
  endtask

  task automatic wait_acc(input logic [AW-1:0] a);
    int t = 0;
    while (!(psel && penable && paddr == a) && t < 2000) begin @(negedge clk); t++; end
    check("wait_access", psel && penable && paddr == a, 1'b1);
  endtask

  task automatic fire_irq();
    int t = 0;
    @(negedge clk); irq = 1'b1;
    while (irq && t < 2000) begin @(negedge clk); t++; end
    check("irq_serviced", irq, 1'b0);
    irq = 1'b0;
  endtask

  task automatic wait_end();
    int t = 0;
    while (exp_end.size() != 0 && t < 5000) begin @(negedge clk); t++; end
    check("end_seen", exp_end.size(), 0);
    repeat (10) @(negedge clk);
    check("leftover_writes", exp_addr.size(), 0);
  endtask

  initial begin
    int b;
    logic [DW-1:0] pr, vr, arr;
    int ev;

    repeat (3) @(negedge clk);
    check("rst_bus", {psel, penable, pwrite, pstrb}, '0);
    check("rst_addr_data", {paddr, pwdata}, '0);
    check("rst_status", {busy, done, err, pause_ack, event_cnt}, '0);
    rst_n = 1'b1;

    // Basic run with stray start/stop pulses that must be ignored.
    ws = 0; b = wr_done;
    push_seq(50, 5, 20, 3, -1, 3);
    start_seq(50, 5, 20, 3);
    @(negedge clk); start = 1'b1; stop = 1'b1; cfg_pr = 32'hDEAD;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    check("busy_running", busy, 1'b1);
    wait_writes(b + 6);
    repeat (3) fire_irq();
    wait_end();

    // Wait states on every ACCESS.
    ws = 4; b = wr_done;
    push_seq(50, 5, 20, 3, -1, 3);
    start_seq(50, 5, 20, 3);
    wait_writes(b + 6);
    repeat (3) fire_irq();
    wait_end();

    // Continuous run ended by stop coincident with irq.
    ws = 0; b = wr_done;
    push_seq(32'h1234, 32'h77, 32'h999, 7, -1, 7);
    start_seq(32'h1234, 32'h77, 32'h999, 16'd0);
    wait_writes(b + 6);
    repeat (7) fire_irq();
    repeat (2) @(negedge clk);
    irq = 1'b1; stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_end();
    irq = 1'b0;

    // Slave error on the VR write aborts the run.
    err_en = 1'b1; err_addr = BASE + 32'h08;
    push_seq(1, 2, 3, 0, 3, 0);
    start_seq(1, 2, 3, 2);
    wait_end();
    check("busy_after_err", busy, 1'b0);
    err_en = 1'b0;

    // Pause requested mid-sequence, irq held while paused.
    ws = 1; b = wr_done;
    push_seq(7, 8, 9, 1, -1, 1);
    start_seq(7, 8, 9, 1);
    wait_acc(BASE + 32'h04);
    pause_req = 1'b1;
    begin
      int t = 0;
      while (!pause_ack && t < 500) begin @(negedge clk); t++; end
    end
    check("pause_ack", pause_ack, 1'b1);
    check("setup_writes_before_pause", wr_done - b, 6);
    irq = 1'b1;
    repeat (10) @(negedge clk);
    check("no_writes_paused", wr_done - b, 6);
    check("still_paused", {pause_ack, busy, irq}, 3'b111);
    pause_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pause_ack_dropped", pause_ack, 1'b0);
    wait_end();
    check("irq_serviced_after_resume", irq, 1'b0);

    // Reset in the middle of the ARR ACCESS.
    ws = 2;
    push_seq(11, 12, 13, 1, -1, 1);
    start_seq(11, 12, 13, 1);
    wait_acc(BASE + 32'h0C);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_bus", {psel, penable, busy, event_cnt}, '0);
    exp_addr.delete(); exp_data.delete(); exp_end.delete(); exp_cnt.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b = wr_done;
    push_seq(21, 22, 23, 2, -1, 2);
    start_seq(21, 22, 23, 2);
    wait_writes(b + 6);
    repeat (2) fire_irq();
    wait_end();

    // Randomized runs.
    for (int k = 0; k < 6; k++) begin
      pr = $urandom; vr = $urandom; arr = $urandom;
      ev = $urandom_range(1, 4);
      ws = $urandom_range(0, 2);
      b = wr_done;
      push_seq(pr, vr, arr, ev, -1, 16'(ev));
      start_seq(pr, vr, arr, 16'(ev));
      wait_writes(b + 6);
      repeat (ev) fire_irq();
      wait_end();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
